// File: rtl/sound_sequencer.sv
// sound_sequencer: IDLE/RECORD/PLAY mode controller between the ADC front end, the shared
//   single-port sample RAM and the DAC driver; owns the sample timebase and RAM arbitration.
// Latency: requests change mode on the next edge; RAM write 1 cycle after adc_done; dac_data 2 cycles after tick.
// Backpressure: none; a sample tick that finds a conversion still pending is skipped and flags overrun.
//
// Ports:
//   clk, reset_n_clk            clock, asynchronous active-low reset
//   record_req/play_req/stop_req 1-cycle request pulses (stop > record > play)
//   adc_start/adc_done/adc_data  conversion handshake with the ADC interface
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port sample RAM (1-cycle synchronous read)
//   dac_data/dac_en             playback sample and unmute
//   mode/rec_length/overrun     status: 0 IDLE 1 RECORD 2 PLAY, stored length, sticky overrun
//
// Build option: define SOUND_SEQ_LOOP_PLAY_EN to loop playback until stop_req
// (default: one-shot, last sample held until the next tick, then IDLE).

module sound_sequencer #(
  parameter int SAMPLE_INTERVAL_CLK = 3000,
  parameter int ADDR_W              = 19,
  parameter int DATA_W              = 10
) (
  input  logic              clk,
  input  logic              reset_n_clk,
  input  logic              record_req,
  input  logic              play_req,
  input  logic              stop_req,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_en,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] rec_length,
  output logic              overrun
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RECORD = 2'd1,
    MODE_PLAY   = 2'd2
  } mode_e;

  localparam int CNT_W = (SAMPLE_INTERVAL_CLK > 1) ? $clog2(SAMPLE_INTERVAL_CLK) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_INTERVAL_CLK - 1);
  localparam logic [ADDR_W-1:0] LEN_FULL = '1;   // capacity 2^ADDR_W-1 samples
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              adc_start_q, adc_start_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_commit_q, wr_commit_d;   // write in flight: bump wr_ptr/rec_length next edge
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rec_length_q, rec_length_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rd_s1_q, rd_s1_d;           // address presented this cycle
  logic              rd_s2_q, rd_s2_d;           // RAM data valid this cycle
  logic              last_hold_q, last_hold_d;   // last sample on the DAC, leave at next tick
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_en_q, dac_en_d;
  logic              tick;
  logic              rd_last;

  // Tick fires on the edge where the timebase wraps N-1 -> 0.
  assign tick    = (mode_q != MODE_IDLE) && (tcnt_q == CNT_LAST);
  assign rd_last = (rd_ptr_q == (rec_length_q - ADDR_ONE));

  always_comb begin
    mode_d       = mode_q;
    tcnt_d       = '0;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    adc_start_d  = 1'b0;
    mem_we_d     = 1'b0;
    wr_commit_d  = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    wr_ptr_d     = wr_ptr_q;
    rec_length_d = rec_length_q;
    rd_ptr_d     = rd_ptr_q;
    rd_s1_d      = 1'b0;
    rd_s2_d      = 1'b0;
    last_hold_d  = last_hold_q;
    dac_data_d   = dac_data_q;
    dac_en_d     = dac_en_q;

    if (mode_q != MODE_IDLE && !tick) begin
      tcnt_d = tcnt_q + CNT_W'(1);
    end

    // A write accepted on the previous edge completes even if the mode is left now.
    if (wr_commit_q) begin
      wr_ptr_d     = wr_ptr_q + ADDR_ONE;
      rec_length_d = rec_length_q + ADDR_ONE;
    end

    case (mode_q)
      MODE_IDLE: begin
        if (record_req) begin
          mode_d       = MODE_RECORD;
          tcnt_d       = '0;
          wr_ptr_d     = '0;
          rec_length_d = '0;
          overrun_d    = 1'b0;
          pending_d    = 1'b0;
        end else if (play_req && (rec_length_q != '0)) begin
          mode_d      = MODE_PLAY;
          tcnt_d      = '0;
          rd_ptr_d    = '0;
          last_hold_d = 1'b0;
          dac_data_d  = '0;
          dac_en_d    = 1'b1;
        end
      end

      MODE_RECORD: begin
        if (stop_req) begin
          // Any pending conversion is abandoned; its adc_done will be ignored.
          mode_d    = MODE_IDLE;
          pending_d = 1'b0;
        end else begin
          if (tick) begin
            if (pending_q) begin
              overrun_d = 1'b1;
            end else begin
              adc_start_d = 1'b1;
              pending_d   = 1'b1;
            end
          end
          if (adc_done && pending_q) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = adc_data;
            wr_commit_d = 1'b1;
            pending_d   = 1'b0;
          end
          // Buffer full once this commit lands: stop without starting another conversion.
          if (wr_commit_q && ((rec_length_q + ADDR_ONE) == LEN_FULL)) begin
            mode_d      = MODE_IDLE;
            pending_d   = 1'b0;
            adc_start_d = 1'b0;
            mem_we_d    = 1'b0;
            wr_commit_d = 1'b0;
          end
        end
      end

      MODE_PLAY: begin
        if (tick && !last_hold_q) begin
          rd_s1_d = 1'b1;
        end
        rd_s2_d = rd_s1_q;
        if (rd_s2_q) begin
          dac_data_d = mem_rdata;
          if (rd_last) begin
`ifdef SOUND_SEQ_LOOP_PLAY_EN
            rd_ptr_d = '0;
`else
            rd_ptr_d    = rd_ptr_q + ADDR_ONE;
            last_hold_d = 1'b1;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_ONE;
          end
        end
        if (stop_req || (tick && last_hold_q)) begin
          // Exit drops any read in flight and mutes the output on the same edge.
          mode_d      = MODE_IDLE;
          dac_en_d    = 1'b0;
          dac_data_d  = '0;
          rd_ptr_d    = '0;
          rd_s1_d     = 1'b0;
          rd_s2_d     = 1'b0;
          last_hold_d = 1'b0;
        end
      end

      default: begin
        mode_d = MODE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      mode_q       <= MODE_IDLE;
      tcnt_q       <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      adc_start_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      wr_commit_q  <= 1'b0;
      mem_wdata_q  <= '0;
      wr_ptr_q     <= '0;
      rec_length_q <= '0;
      rd_ptr_q     <= '0;
      rd_s1_q      <= 1'b0;
      rd_s2_q      <= 1'b0;
      last_hold_q  <= 1'b0;
      dac_data_q   <= '0;
      dac_en_q     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      tcnt_q       <= tcnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      adc_start_q  <= adc_start_d;
      mem_we_q     <= mem_we_d;
      wr_commit_q  <= wr_commit_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rec_length_q <= rec_length_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_s1_q      <= rd_s1_d;
      rd_s2_q      <= rd_s2_d;
      last_hold_q  <= last_hold_d;
      dac_data_q   <= dac_data_d;
      dac_en_q     <= dac_en_d;
    end
  end

  assign adc_start  = adc_start_q;
  assign mem_addr   = (mode_q == MODE_RECORD) ? wr_ptr_q : rd_ptr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign dac_data   = dac_data_q;
  assign dac_en     = dac_en_q;
  assign mode       = mode_q;
  assign rec_length = rec_length_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sound_sequencer.sv
module tb_sound_sequencer;
  localparam int N  = 8;
  localparam int AW = 4;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset_n_clk = 1'b0;
  logic          record_req = 1'b0, play_req = 1'b0, stop_req = 1'b0;
  logic          adc_start, adc_done = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic [DW-1:0] dac_data;
  logic          dac_en;
  logic [1:0]    mode;
  logic [AW-1:0] rec_length;
  logic          overrun;

  sound_sequencer #(.SAMPLE_INTERVAL_CLK(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n_clk(reset_n_clk),
    .record_req(record_req), .play_req(play_req), .stop_req(stop_req),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dac_data(dac_data), .dac_en(dac_en), .mode(mode),
    .rec_length(rec_length), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int wr_cnt = 0;
  logic [AW-1:0] wr_addr_log [0:31];
  logic [DW-1:0] wr_data_log [0:31];
  logic [DW-1:0] ram [0:15];
  logic [DW-1:0] adc_vals [0:15];
  int  adc_idx = 0;
  bit  adc_resp_en = 1'b0;

  // Environment: RAM with 1-cycle synchronous read, write/start monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    if (adc_start) start_cnt++;
    if (mem_we) begin
      wr_addr_log[wr_cnt[4:0]] = mem_addr;
      wr_data_log[wr_cnt[4:0]] = mem_wdata;
      wr_cnt++;
    end
  end

  // ADC: answers adc_done about 3 cycles after each adc_start when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (adc_start && adc_resp_en) begin
        repeat (2) @(negedge clk);
        adc_done = 1'b1;
        adc_data = adc_vals[adc_idx[3:0]];
        adc_idx++;
        @(negedge clk);
        adc_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit r, input bit p, input bit s);
    record_req = r; play_req = p; stop_req = s;
    @(negedge clk);
    record_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
  endtask

  task automatic wait_dac_change(input logic [DW-1:0] prev, input string tag, output int t);
    int i;
    i = 0;
    while (dac_data === prev && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(i < 40), 32'd1);
    t = cyc;
  endtask

  initial begin
    int s0, w0, t1, t2, t3, t4, i;
    for (int k = 0; k < 16; k++) begin
      ram[k] = '0;
      adc_vals[k] = DW'(k * 3 + 5);
    end
    adc_vals[0] = 10'h11; adc_vals[1] = 10'h22; adc_vals[2] = 10'h33;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_start", 32'(adc_start), 32'd0);
    chk("rst_dac", 32'({dac_en, dac_data}), 32'd0);
    chk("rst_len", 32'(rec_length), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    reset_n_clk = 1'b1;
    @(negedge clk);

    // Record three samples, then stop
    adc_resp_en = 1'b1; adc_idx = 0;
    pulse(1, 0, 0);
    chk("rec_mode", 32'(mode), 32'd1);
    i = 0;
    while (wr_cnt < 3 && i < 100) begin @(negedge clk); i++; end
    chk("rec3_tmo", 32'(i < 100), 32'd1);
    pulse(0, 0, 1);
    @(negedge clk);
    chk("rec3_mode", 32'(mode), 32'd0);
    chk("rec3_len", 32'(rec_length), 32'd3);
    chk("rec3_wcnt", 32'(wr_cnt), 32'd3);
    chk("rec3_a0", 32'({wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]}), 32'h012);
    chk("rec3_d0", 32'(wr_data_log[0]), 32'h11);
    chk("rec3_d1", 32'(wr_data_log[1]), 32'h22);
    chk("rec3_d2", 32'(wr_data_log[2]), 32'h33);
    chk("rec3_ovr", 32'(overrun), 32'd0);

    // Playback of the three samples
    pulse(0, 1, 0);
    chk("play_mode", 32'(mode), 32'd2);
    chk("play_en", 32'(dac_en), 32'd1);
    chk("play_dac0", 32'(dac_data), 32'd0);
    wait_dac_change(10'h000, "play_s0_tmo", t1);
    chk("play_s0", 32'(dac_data), 32'h11);
    wait_dac_change(10'h011, "play_s1_tmo", t2);
    chk("play_s1", 32'(dac_data), 32'h22);
    chk("play_gap1", 32'(t2 - t1), 32'(N));
    wait_dac_change(10'h022, "play_s2_tmo", t3);
    chk("play_s2", 32'(dac_data), 32'h33);
    chk("play_gap2", 32'(t3 - t2), 32'(N));
`ifdef SOUND_SEQ_LOOP_PLAY_EN
    wait_dac_change(10'h033, "loop_tmo", t4);
    chk("loop_s0", 32'(dac_data), 32'h11);
    chk("loop_gap", 32'(t4 - t3), 32'(N));
    chk("loop_mode", 32'(mode), 32'd2);
    pulse(0, 0, 1);
    chk("loop_stop", 32'({mode, dac_en}), 32'd0);
`else
    i = 0;
    while (dac_en === 1'b1 && i < 40) begin @(negedge clk); i++; end
    t4 = cyc;
    chk("play_end_tmo", 32'(i < 40), 32'd1);
    chk("play_hold", 32'(t4 - t3), 32'(N - 2));
    chk("play_end_dac", 32'(dac_data), 32'd0);
    chk("play_end_mode", 32'(mode), 32'd0);
`endif

    // record_req + play_req together in IDLE: record wins
    pulse(1, 1, 0);
    chk("prio_rec", 32'(mode), 32'd1);
    chk("prio_len", 32'(rec_length), 32'd0);
    pulse(0, 0, 1);
    chk("prio_stop", 32'(mode), 32'd0);

    // play_req with nothing recorded is ignored
    pulse(0, 1, 0);
    chk("play_empty", 32'({mode, dac_en}), 32'd0);

    // ADC never answers: one start, overrun at second tick, no writes
    adc_resp_en = 1'b0;
    s0 = start_cnt; w0 = wr_cnt;
    pulse(1, 0, 0);
    repeat (10) @(negedge clk);
    chk("ovr_start1", 32'(start_cnt - s0), 32'd1);
    chk("ovr_early", 32'(overrun), 32'd0);
    repeat (7) @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_start2", 32'(start_cnt - s0), 32'd1);
    chk("ovr_nowr", 32'(wr_cnt - w0), 32'd0);
    pulse(0, 0, 1);
    chk("ovr_sticky", 32'({mode, overrun}), 32'd1);

    // Record until full
    adc_resp_en = 1'b1; adc_idx = 0;
    s0 = start_cnt; w0 = wr_cnt;
    pulse(1, 0, 0);
    chk("full_ovr_clr", 32'(overrun), 32'd0);
    i = 0;
    while (mode !== 2'd0 && i < 300) begin @(negedge clk); i++; end
    chk("full_tmo", 32'(i < 300), 32'd1);
    chk("full_len", 32'(rec_length), 32'd15);
    chk("full_wcnt", 32'(wr_cnt - w0), 32'd15);
    chk("full_last_addr", 32'(wr_addr_log[(wr_cnt - 1) % 32]), 32'd14);
    repeat (20) @(negedge clk);
    chk("full_starts", 32'(start_cnt - s0), 32'd15);

    // stop_req + record_req in PLAY: stop wins
    pulse(0, 1, 0);
    chk("p2_mode", 32'(mode), 32'd2);
    repeat (12) @(negedge clk);
    chk("p2_s0", 32'(dac_data), 32'(adc_vals[0]));
    pulse(1, 0, 1);
    chk("p2_stop", 32'({mode, dac_en}), 32'd0);
    chk("p2_dac", 32'(dac_data), 32'd0);
    chk("p2_len", 32'(rec_length), 32'd15);

    // Async reset mid-record
    w0 = wr_cnt;
    pulse(1, 0, 0);
    i = 0;
    while (wr_cnt - w0 < 2 && i < 100) begin @(negedge clk); i++; end
    while (mem_we !== 1'b1 && i < 120) begin @(negedge clk); i++; end
    chk("arst_tmo", 32'(i < 120), 32'd1);
    chk("arst_pre_len", 32'(rec_length), 32'd2);
    reset_n_clk = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_len", 32'(rec_length), 32'd0);
    @(negedge clk);
    reset_n_clk = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
